// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: two-port round-robin issue controller for a shared 8-bit
// combinational ALU. It grants one command at a time, drives the ALU from a
// command register, owns the NZCV flag register and returns a tagged response.
module alu_issue_ctrl #(
  parameter int DATA_W = 8,
  parameter int OP_W   = 4,
  parameter int CMD_W  = 2*DATA_W+OP_W+3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [CMD_W-1:0]  req0_cmd,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [CMD_W-1:0]  req1_cmd,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_control,
  output logic              alu_cond_is_zero,
  output logic              alu_cond_is_negative,
  output logic              alu_cond_is_overflow,
  output logic              alu_cond_is_always,
  output logic              alu_cond_update,
  output logic [3:0]        alu_inst_conds,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [3:0]        alu_flags,
  input  logic              alu_cpsr_write,
  input  logic              alu_cond_satisfy,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_executed,
  output logic              rsp_err,
  output logic [3:0]        cpsr_nzcv
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  // Command field positions, MSB first: {upd, cond_sel, op, a, b}
  localparam int B_LO    = 0;
  localparam int A_LO    = DATA_W;
  localparam int OP_LO   = 2*DATA_W;
  localparam int COND_LO = 2*DATA_W+OP_W;
  localparam int UPD_BIT = CMD_W-1;

  state_t                    state_q, state_d;
  logic [CMD_W-1:0]          cmd_q, cmd_d;
  logic                      id_q, id_d;
  logic                      last_q, last_d;
  logic [3:0]                flags_q, flags_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]         rsp_data_q, rsp_data_d;
  logic                      rsp_exec_q, rsp_exec_d;
  logic                      rsp_err_q, rsp_err_d;

  logic [1:0]                req_valid;
  logic [1:0][CMD_W-1:0]     req_cmd;
  logic [1:0]                ready;
  logic                      gnt_id;
  logic [1:0]                cond_sel;
  logic [OP_W-1:0]           op;
  logic                      op_illegal;

  assign req_valid = {req1_valid, req0_valid};
  assign req_cmd   = {req1_cmd, req0_cmd};
  assign req0_ready = ready[0];
  assign req1_ready = ready[1];

  // ALU is driven straight from the command register in every state
  assign op          = cmd_q[OP_LO +: OP_W];
  assign cond_sel    = cmd_q[COND_LO +: 2];
  assign alu_a       = cmd_q[A_LO +: DATA_W];
  assign alu_b       = cmd_q[B_LO +: DATA_W];
  assign alu_control = op;
  assign alu_cond_update      = cmd_q[UPD_BIT];
  assign alu_cond_is_always   = (cond_sel == 2'b00);
  assign alu_cond_is_zero     = (cond_sel == 2'b01);
  assign alu_cond_is_negative = (cond_sel == 2'b10);
  assign alu_cond_is_overflow = (cond_sel == 2'b11);
  assign alu_inst_conds = flags_q;
  assign cpsr_nzcv      = flags_q;

  // Opcodes 1100..1111 are illegal
  assign op_illegal = (op[OP_W-1 -: 2] == 2'b11);

  // On contention the port that did not win last time goes next
  assign gnt_id = (&req_valid) ? ~last_q : req_valid[1];

  assign rsp_valid    = rsp_valid_q;
  assign rsp_id       = id_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_executed = rsp_exec_q;
  assign rsp_err      = rsp_err_q;

  // Next-state, grant and response capture
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    id_d        = id_q;
    last_d      = last_q;
    flags_d     = flags_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_exec_d  = rsp_exec_q;
    rsp_err_d   = rsp_err_q;
    ready       = 2'b00;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          ready[gnt_id] = 1'b1;
          cmd_d   = req_cmd[gnt_id];
          id_d    = gnt_id;
          last_d  = gnt_id;
          state_d = EXEC;
        end
      end
      EXEC: begin
        rsp_valid_d = 1'b1;
        state_d     = RESP;
        if (op_illegal) begin
          rsp_err_d  = 1'b1;
          rsp_exec_d = 1'b0;
          rsp_data_d = '0;
        end else begin
          rsp_err_d  = 1'b0;
          rsp_exec_d = alu_cond_satisfy;
          rsp_data_d = alu_cond_satisfy ? alu_out : '0;
          if (alu_cond_satisfy && alu_cpsr_write) flags_d = alu_flags;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset aborts any op in flight and clears the flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      id_q        <= 1'b0;
      last_q      <= 1'b1;
      flags_q     <= 4'b0000;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_exec_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      id_q        <= id_d;
      last_q      <= last_d;
      flags_q     <= flags_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_exec_q  <= rsp_exec_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

endmodule
